// File: rtl/serial_cla_subtractor_if.sv
// rtl/serial_cla_subtractor_if.sv - request/result bundle for the group-serial CLA subtractor.
interface serial_cla_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf
  );
endinterface

// File: rtl/serial_cla_subtractor.sv
// rtl/serial_cla_subtractor.sv - a - b - bin, one GROUP-bit lookahead slice per cycle.
// Optional zero/ovf flags are built when SERIAL_SUB_FLAGS_EN is defined; otherwise they read 0.
module serial_cla_subtractor #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_cla_subtractor_if.slave sub
);
  localparam int NG = WIDTH / GROUP;
  localparam int KW = (NG > 1) ? $clog2(NG) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [KW-1:0]    k;
  logic             c;
  logic             bout_q;

  logic [BW-1:0]    base;
  logic [GROUP-1:0] a_grp;
  logic [GROUP-1:0] nb_grp;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] sum;
  logic [GROUP:0]   carry;
  logic [WIDTH-1:0] diff_next;
  logic             pp;

  wire accept    = (state == S_IDLE) && sub.start;
  wire last_grp  = (state == S_RUN) && (k == K_LAST);

  // Subtraction as a + ~b + 1: the initial carry is the inverted borrow-in,
  // and each carry is expanded as a flat sum of generate/propagate products.
  always_comb begin
    base   = BW'(k) * BW'(GROUP);
    a_grp  = a_q[base +: GROUP];
    nb_grp = ~b_q[base +: GROUP];
    p      = a_grp ^ nb_grp;
    g      = a_grp & nb_grp;
    carry  = '0;
    pp     = 1'b0;
    carry[0] = c;
    for (int i = 0; i < GROUP; i++) begin
      pp = 1'b1;
      for (int m = 0; m <= i; m++) pp = pp & p[m];
      carry[i+1] = pp & c;
      for (int j = 0; j <= i; j++) begin
        pp = g[j];
        for (int m = j + 1; m <= i; m++) pp = pp & p[m];
        carry[i+1] = carry[i+1] | pp;
      end
    end
    sum       = p ^ carry[GROUP-1:0];
    diff_next = diff_q;
    diff_next[base +: GROUP] = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      c      <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sub.start) begin
            a_q    <= sub.a;
            b_q    <= sub.b;
            k      <= '0;
            c      <= ~sub.bin;
            diff_q <= '0;
            bout_q <= 1'b0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q <= diff_next;
          c      <= carry[GROUP];
          if (k == K_LAST) begin
            k      <= '0;
            bout_q <= ~carry[GROUP];
            state  <= S_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sub.busy = (state != S_IDLE);
  assign sub.done = (state == S_DONE);
  assign sub.diff = diff_q;
  assign sub.bout = bout_q;

`ifdef SERIAL_SUB_FLAGS_EN
  logic zero_q;
  logic ovf_q;

  // Flags are taken from the fully assembled difference on the last group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_grp) begin
      zero_q <= (diff_next == '0);
      ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_next[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign sub.zero = zero_q;
  assign sub.ovf  = ovf_q;
`else
  wire unused_flags = accept ^ last_grp;
  assign sub.zero = 1'b0;
  assign sub.ovf  = 1'b0;
`endif
endmodule
